// File: rtl/adder_error_monitor.sv
// adder_error_monitor: drives every operand pair into a W-bit approximate adder and
// accumulates error count, worst-case error and saturating summed error of its sum.
`default_nettype none

module adder_error_monitor #(
  parameter int W     = 2,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W:0]       dut_sum,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_count,
  output logic [W:0]       err_max,
  output logic [ACC_W-1:0] err_sum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2*W-1:0] K_ONE   = (2*W)'(1);
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic [1:0]       state;
  logic [2*W-1:0]   k;
  logic             cap_valid;
  logic [W:0]       cap_dut;
  logic [W:0]       cap_exact;

  logic [W:0]       exact_sum;
  logic [W:0]       diff;
  logic [ACC_W:0]   sum_ext;
  logic             start_ok;

  // Operands come straight from the vector counter, so they are registered.
  assign op_a = k[2*W-1:W];
  assign op_b = k[W-1:0];

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
  assign diff      = (cap_dut >= cap_exact) ? (cap_dut - cap_exact) : (cap_exact - cap_dut);
  assign sum_ext   = {1'b0, err_sum} + {{(ACC_W-W){1'b0}}, diff};
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      cap_valid <= 1'b0;
      cap_dut   <= '0;
      cap_exact <= '0;
      err_count <= '0;
      err_max   <= '0;
      err_sum   <= '0;
    end else begin
      // Accumulate stage; the clears of an accepted start below take precedence.
      if (cap_valid) begin
        if ((diff != '0) && !(&err_count)) begin
          err_count <= err_count + ACC_ONE;
        end
        if (diff > err_max) begin
          err_max <= diff;
        end
        err_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state     <= S_RUN;
            k         <= '0;
            cap_valid <= 1'b0;
            err_count <= '0;
            err_max   <= '0;
            err_sum   <= '0;
          end
        end
        S_RUN: begin
          cap_dut   <= dut_sum;
          cap_exact <= exact_sum;
          cap_valid <= 1'b1;
          k         <= k + K_ONE;
          if (&k) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cap_valid <= 1'b0;
          state     <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor: table of adder fault models with expected error
// statistics, plus directed sequences for reset, ignored start and saturation.
`default_nettype none

module tb_adder_error_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op_a, op_b;
  logic [2:0]  dut_sum;
  logic        busy, done;
  logic [15:0] err_count, err_sum;
  logic [2:0]  err_max;

  logic [1:0]  op_a_s, op_b_s;
  logic        busy_s, done_s;
  logic [3:0]  err_count_s, err_sum_s;
  logic [2:0]  err_max_s;

  int mode;
  int checks;
  int errors;

  typedef struct {
    int mode;
    int cnt;
    int mx;
    int sm;
  } vec_t;

  vec_t tbl[3];

  adder_error_monitor #(.W(2), .ACC_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .dut_sum(dut_sum),
    .busy(busy), .done(done), .err_count(err_count), .err_max(err_max), .err_sum(err_sum)
  );

  // Narrow-accumulator instance watching an adder stuck at zero.
  adder_error_monitor #(.W(2), .ACC_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a_s), .op_b(op_b_s), .dut_sum(3'b000),
    .busy(busy_s), .done(done_s), .err_count(err_count_s), .err_max(err_max_s), .err_sum(err_sum_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_sum = 3'b000;
    case (mode)
      0: dut_sum = {1'b0, op_a} + {1'b0, op_b};
      1: dut_sum = 3'b000;
      default: dut_sum = ({1'b0, op_a} + {1'b0, op_b}) & 3'b011;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Launch a sweep, verify cleared accumulators and vector order, count busy cycles.
  // inject_at >= 0 raises start for one cycle at that loop index while running.
  task automatic sweep(input int inject_at, output int bcyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_done", int'(done), 0);
    chk("clear_count", int'(err_count), 0);
    chk("clear_max", int'(err_max), 0);
    chk("clear_sum", int'(err_sum), 0);
    bcyc = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (busy) begin
        if (bcyc < 16) chk("vector_order", int'({op_a, op_b}), bcyc);
        bcyc++;
      end
      start = (i == inject_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic chk_results(input string tag, input int c, input int m, input int s);
    chk({tag, "_err_count"}, int'(err_count), c);
    chk({tag, "_err_max"}, int'(err_max), m);
    chk({tag, "_err_sum"}, int'(err_sum), s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_op_a"}, int'(op_a), 0);
    chk({tag, "_op_b"}, int'(op_b), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_err_max"}, int'(err_max), 0);
    chk({tag, "_err_sum"}, int'(err_sum), 0);
  endtask

  initial begin
    int b;
    checks = 0;
    errors = 0;
    mode   = 0;
    rst    = 1'b1;
    start  = 1'b0;

    tbl[0] = '{mode: 0, cnt: 0,  mx: 0, sm: 0};
    tbl[1] = '{mode: 1, cnt: 15, mx: 6, sm: 48};
    tbl[2] = '{mode: 2, cnt: 6,  mx: 4, sm: 24};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    for (int t = 0; t < 3; t++) begin
      mode = tbl[t].mode;
      sweep(-1, b);
      chk("busy_cycles", b, 17);
      chk_results("table", tbl[t].cnt, tbl[t].mx, tbl[t].sm);
    end

    chk("sat_err_count", int'(err_count_s), 15);
    chk("sat_err_max", int'(err_max_s), 6);
    chk("sat_err_sum", int'(err_sum_s), 15);

    // Reset in the middle of a sweep, then a clean sweep.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_count_nonzero", int'(err_count != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrun_rst");
    sweep(-1, b);
    chk("rerun_busy_cycles", b, 17);
    chk_results("rerun", 15, 6, 48);

    // Start pulsed while running is ignored; a restart from DONE repeats the result.
    mode = 2;
    sweep(3, b);
    chk("ignored_start_busy_cycles", b, 17);
    chk_results("ignored_start", 6, 4, 24);
    sweep(-1, b);
    chk("repeat_busy_cycles", b, 17);
    chk_results("repeat", 6, 4, 24);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_all_zero("rst_start");
    @(negedge clk);
    chk("rst_start_stays_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
